nios_qsys_shmem_ring_reader: RTL

NIOS_QSYS_SHMEM_RING_READER -- requirements
Module: nios_qsys_shmem_ring_reader

---
 rtl/nios_qsys_shmem_ring_reader.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/nios_qsys_shmem_ring_reader.sv
// nios_qsys_shmem_ring_reader
//
// Consumer side of a single-producer ring buffer held in a shared on-chip RAM.
// Word BASE_WORD holds the producer write index. Word BASE_WORD+1 holds the
// consumer read index. The RING_DEPTH data words start at BASE_WORD+2.
// The block polls the write index, reads pending words, and presents them on a
// valid/ready stream. After each word is taken it writes back the new read index.
//
// Optional feature: define SHMEM_RING_IDX_CHECK_EN to reject out-of-range write
// indices. A rejected index raises the sticky err flag and is treated as an
// empty ring.
//
// Ports:
//   clk, reset          single clock; synchronous active-high reset
//   enable              gates the start of each write-index poll
//   m_address           shared-memory word address (10 bits)
//   m_chipselect        access strobe
//   m_write             write qualifier
//   m_writedata         write data
//   m_byteenable        always 4'hF
//   m_clken             always 1
//   m_readdata          read data, valid one cycle after a read strobe
//   out_data            dequeued word
//   out_valid           stream valid
//   out_ready           stream ready
//   err                 sticky bad-index flag (tied 0 without the check)

module nios_qsys_shmem_ring_reader #(
    parameter int unsigned BASE_WORD     = 0,
    parameter int unsigned RING_DEPTH    = 256,
    parameter int unsigned POLL_INTERVAL = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic [9:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write,
    output logic [31:0] m_writedata,
    output logic [3:0]  m_byteenable,
    output logic        m_clken,
    input  logic [31:0] m_readdata,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        err
);

    localparam int unsigned IW = $clog2(RING_DEPTH);
    localparam int unsigned CW = $clog2(POLL_INTERVAL + 1);

    localparam logic [9:0]    WIDX_ADDR = 10'(BASE_WORD);
    localparam logic [9:0]    RIDX_ADDR = 10'(BASE_WORD + 1);
    localparam logic [9:0]    DATA_ADDR = 10'(BASE_WORD + 2);
    localparam logic [CW-1:0] POLL_LOAD = CW'(POLL_INTERVAL);

    typedef enum logic [2:0] {
        StInit,
        StPollWait,
        StRdWidx,
        StCapWidx,
        StRdData,
        StCapData,
        StOut,
        StWrRidx
    } state_e;

    state_e        state_q;
    logic [IW-1:0] ridx_q;
    logic [IW-1:0] widx_q;
    logic [CW-1:0] poll_cnt_q;
    // INIT idles one cycle before its write, so the bus stays quiet in the
    // cycle straight after reset.
    logic          init_armed_q;

    logic [IW-1:0] widx_rd;
    logic          widx_bad;

    assign widx_rd = m_readdata[IW-1:0];

`ifdef SHMEM_RING_IDX_CHECK_EN
    logic err_q;
    assign widx_bad = (m_readdata >= 32'(RING_DEPTH));
    assign err      = err_q;
`else
    assign widx_bad = 1'b0;
    assign err      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StInit;
            ridx_q       <= '0;
            widx_q       <= '0;
            poll_cnt_q   <= '0;
            init_armed_q <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
`ifdef SHMEM_RING_IDX_CHECK_EN
            err_q        <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StInit: begin
                    if (init_armed_q) begin
                        state_q <= StRdWidx;
                    end else begin
                        init_armed_q <= 1'b1;
                    end
                end
                StPollWait: begin
                    if (poll_cnt_q <= CW'(1)) begin
                        poll_cnt_q <= '0;
                        state_q    <= StRdWidx;
                    end else begin
                        poll_cnt_q <= poll_cnt_q - CW'(1);
                    end
                end
                StRdWidx: begin
                    if (enable) begin
                        state_q <= StCapWidx;
                    end
                end
                StCapWidx: begin
                    if (widx_bad) begin
`ifdef SHMEM_RING_IDX_CHECK_EN
                        err_q <= 1'b1;
`endif
                        poll_cnt_q <= POLL_LOAD;
                        state_q    <= StPollWait;
                    end else begin
                        widx_q <= widx_rd;
                        // Compare against the fresh value, not the stale widx_q.
                        if (widx_rd != ridx_q) begin
                            state_q <= StRdData;
                        end else begin
                            poll_cnt_q <= POLL_LOAD;
                            state_q    <= StPollWait;
                        end
                    end
                end
                StRdData: begin
                    state_q <= StCapData;
                end
                StCapData: begin
                    out_data  <= m_readdata;
                    out_valid <= 1'b1;
                    state_q   <= StOut;
                end
                StOut: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        ridx_q    <= ridx_q + IW'(1);
                        state_q   <= StWrRidx;
                    end
                end
                StWrRidx: begin
                    // More words already known to be pending: skip the re-poll.
                    if (ridx_q != widx_q) begin
                        state_q <= StRdData;
                    end else begin
                        state_q <= StRdWidx;
                    end
                end
            endcase
        end
    end

    // Bus strobes are decoded from the registered state; only the write-index
    // read also looks at enable.
    always_comb begin
        m_chipselect = 1'b0;
        m_write      = 1'b0;
        m_address    = WIDX_ADDR;
        m_writedata  = '0;
        unique case (state_q)
            StInit: begin
                if (init_armed_q) begin
                    m_chipselect = 1'b1;
                    m_write      = 1'b1;
                    m_address    = RIDX_ADDR;
                end
            end
            StRdWidx: begin
                m_chipselect = enable;
            end
            StRdData: begin
                m_chipselect = 1'b1;
                m_address    = DATA_ADDR + 10'(ridx_q);
            end
            StWrRidx: begin
                m_chipselect = 1'b1;
                m_write      = 1'b1;
                m_address    = RIDX_ADDR;
                m_writedata  = 32'(ridx_q);
            end
            default: begin
            end
        endcase
    end

    assign m_byteenable = 4'hF;
    assign m_clken      = 1'b1;

endmodule
